game_sequencer: RTL and testbench

//  Round/state controller for Frogger. Sequences the start countdown, play, hit-respawn, level-up, win and game-over phases.

---
 rtl/frogger_pkg.sv | 26 ++
 rtl/game_sequencer_tick_divider.sv | 29 ++
 rtl/game_sequencer.sv | 141 ++++++++++++++
 tb/tb_game_sequencer.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/frogger_pkg.sv
// Shared Frogger definitions: sequencer state encodings, counter widths and
// screen geometry used by the sequencer, frog and car blocks.
package frogger_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_PLAY      = 3'd2,
    ST_HIT       = 3'd3,
    ST_LEVELUP   = 3'd4,
    ST_WIN       = 3'd5,
    ST_OVER      = 3'd6
  } state_t;

  localparam int LEVEL_W = 3;
  localparam int LIVES_W = 3;
  localparam int CNT_W   = 28;

  // Frog top at or above this row means the road has been crossed.
  localparam logic [8:0] GOAL_Y = 9'd90;

  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int FROG_SIZE = 16;

endpackage

// File: rtl/game_sequencer_tick_divider.sv
// Loadable period divider: counts enabled cycles and emits a one-cycle wrap
// pulse every i_period cycles. Load (or reset) restarts the count at zero.
module tick_divider
  import frogger_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_period,
  output logic             o_wrap
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_end;

  assign w_at_end = (r_cnt == (i_period - CNT_W'(1)));
  assign o_wrap   = i_en & ~i_load & w_at_end;

  // Period counter: cleared on load, wraps to zero at period-1.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_load) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_at_end ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Frogger round controller: countdown, play, hit-respawn, level-up, win and
// game-over sequencing. Every output is a register.
module game_sequencer #(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned COUNTDOWN_S = 5,
  parameter int unsigned START_LIVES = 3,
  parameter int unsigned MAX_LEVEL   = 5,
  parameter int unsigned TICK_BASE   = 2_000_000,
  parameter int unsigned TICK_STEP   = 250_000,
  parameter int unsigned HIT_HOLD    = 50_000_000,
  parameter logic [8:0]  GOAL_Y      = frogger_pkg::GOAL_Y
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       start_i,
  input  logic       collision_i,
  input  logic [8:0] frogT_i,
  output logic       pseudo_o,
  output logic       move_tick_o,
  output logic [2:0] level_o,
  output logic [2:0] lives_o,
  output logic [2:0] count_o,
  output logic       gamewin_o,
  output logic       gameover_o,
  output logic [2:0] state_o
);
  import frogger_pkg::*;

  state_t             r_state, w_next;
  logic [LIVES_W-1:0] r_lives, w_lives_nxt;
  logic [LEVEL_W-1:0] r_level, w_level_nxt;
  logic [2:0]         r_count, w_count_nxt;
  logic [CNT_W-1:0]   r_hold;
  logic               r_pseudo, r_tick, r_win, r_over;
  logic               w_sec_wrap, w_tick_wrap;
  logic [CNT_W-1:0]   w_period;

  // Move period shrinks linearly with level.
  assign w_period = CNT_W'(TICK_BASE)
                  - (CNT_W'(r_level) - CNT_W'(1)) * CNT_W'(TICK_STEP);

  tick_divider u_sec (
    .i_clk    (clk_in),
    .i_rst    (reset_in),
    .i_load   (r_state != ST_COUNTDOWN),
    .i_en     (r_state == ST_COUNTDOWN),
    .i_period (CNT_W'(CLK_HZ)),
    .o_wrap   (w_sec_wrap)
  );

  tick_divider u_tick (
    .i_clk    (clk_in),
    .i_rst    (reset_in),
    .i_load   (r_state != ST_PLAY),
    .i_en     (r_state == ST_PLAY),
    .i_period (w_period),
    .o_wrap   (w_tick_wrap)
  );

  // Next-state and next lives/level/count; collision outranks reaching the goal.
  always_comb begin
    w_next      = r_state;
    w_lives_nxt = r_lives;
    w_level_nxt = r_level;
    w_count_nxt = r_count;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_next      = ST_COUNTDOWN;
          w_count_nxt = 3'(COUNTDOWN_S);
        end
      end
      ST_COUNTDOWN: begin
        if (w_sec_wrap) begin
          w_count_nxt = r_count - 3'd1;
          if (r_count == 3'd1) w_next = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (collision_i) begin
          w_lives_nxt = r_lives - 3'd1;
          w_next      = (r_lives == 3'd1) ? ST_OVER : ST_HIT;
        end else if (frogT_i <= GOAL_Y) begin
          w_next = (r_level == 3'(MAX_LEVEL)) ? ST_WIN : ST_LEVELUP;
        end
      end
      ST_HIT: begin
        if (r_hold == CNT_W'(HIT_HOLD - 1)) w_next = ST_PLAY;
      end
      ST_LEVELUP: begin
        w_level_nxt = r_level + 3'd1;
        w_count_nxt = 3'(COUNTDOWN_S);
        w_next      = ST_COUNTDOWN;
      end
      ST_WIN, ST_OVER: begin
        if (start_i) begin
          w_lives_nxt = 3'(START_LIVES);
          w_level_nxt = 3'd1;
          w_count_nxt = 3'(COUNTDOWN_S);
          w_next      = ST_COUNTDOWN;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State, score and output registers; hold timer runs only while in HIT.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state  <= ST_IDLE;
      r_lives  <= 3'(START_LIVES);
      r_level  <= 3'd1;
      r_count  <= 3'(COUNTDOWN_S);
      r_hold   <= '0;
      r_pseudo <= 1'b1;
      r_tick   <= 1'b0;
      r_win    <= 1'b0;
      r_over   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_lives  <= w_lives_nxt;
      r_level  <= w_level_nxt;
      r_count  <= w_count_nxt;
      r_hold   <= (r_state == ST_HIT) ? r_hold + CNT_W'(1) : '0;
      r_pseudo <= (w_next != ST_PLAY);
      r_tick   <= w_tick_wrap && (w_next == ST_PLAY);
      r_win    <= (w_next == ST_WIN);
      r_over   <= (w_next == ST_OVER);
    end
  end

  assign state_o     = r_state;
  assign lives_o     = r_lives;
  assign level_o     = r_level;
  assign count_o     = r_count;
  assign pseudo_o    = r_pseudo;
  assign move_tick_o = r_tick;
  assign gamewin_o   = r_win;
  assign gameover_o  = r_over;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with small timing parameters; expected
// output snapshots are queued before each step and compared after it.
module tb_game_sequencer;

  localparam int S_IDLE = 0, S_CD = 1, S_PLAY = 2, S_HIT = 3, S_LUP = 4, S_WIN = 5, S_OVER = 6;

  logic       clk_in = 1'b0;
  logic       reset_in = 1'b1;
  logic       start_i = 1'b0;
  logic       collision_i = 1'b0;
  logic [8:0] frogT_i = 9'd300;
  logic       pseudo_o, move_tick_o, gamewin_o, gameover_o;
  logic [2:0] level_o, lives_o, count_o, state_o;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [15:0] vec;
  } exp_t;

  exp_t sb[$];

  game_sequencer #(
    .CLK_HZ(10), .COUNTDOWN_S(2), .START_LIVES(2), .MAX_LEVEL(2),
    .TICK_BASE(8), .TICK_STEP(2), .HIT_HOLD(5), .GOAL_Y(9'd90)
  ) dut (
    .clk_in(clk_in), .reset_in(reset_in), .start_i(start_i),
    .collision_i(collision_i), .frogT_i(frogT_i),
    .pseudo_o(pseudo_o), .move_tick_o(move_tick_o), .level_o(level_o),
    .lives_o(lives_o), .count_o(count_o), .gamewin_o(gamewin_o),
    .gameover_o(gameover_o), .state_o(state_o)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [15:0] pack(int st, int lv, int lvl, int cnt, int ps, int tk, int w, int o);
    pack = {3'(st), 3'(lv), 3'(lvl), 3'(cnt), 1'(ps), 1'(tk), 1'(w), 1'(o)};
  endfunction

  // Queue the expected snapshot, advance n edges, sample #1 later and compare.
  task automatic run(input int n, input string tag, input int st, input int lv, input int lvl,
                     input int cnt, input int ps, input int tk, input int w, input int o);
    exp_t e;
    logic [15:0] obs;
    e.tag = tag;
    e.vec = pack(st, lv, lvl, cnt, ps, tk, w, o);
    sb.push_back(e);
    repeat (n) @(posedge clk_in);
    #1;
    obs = {state_o, lives_o, level_o, count_o, pseudo_o, move_tick_o, gamewin_o, gameover_o};
    e = sb.pop_front();
    checks++;
    assert (obs === e.vec) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h (st/lives/level/count/ps/tick/win/over)", e.tag, obs, e.vec);
    end
  endtask

  initial begin
    // reset state
    run(2, "reset", S_IDLE, 2, 1, 2, 1, 0, 0, 0);
    reset_in = 1'b0;
    run(3, "idle_hold", S_IDLE, 2, 1, 2, 1, 0, 0, 0);

    // 1: countdown 2,1 in 10-cycle steps, PLAY at 20, first tick 8 later
    start_i = 1'b1;
    run(1, "cd_enter", S_CD, 2, 1, 2, 1, 0, 0, 0);
    start_i = 1'b0;
    run(9, "cd_digit2_end", S_CD, 2, 1, 2, 1, 0, 0, 0);
    run(1, "cd_digit1", S_CD, 2, 1, 1, 1, 0, 0, 0);
    start_i = 1'b1;
    run(1, "cd_start_ignored", S_CD, 2, 1, 1, 1, 0, 0, 0);
    start_i = 1'b0;
    run(8, "cd_digit1_end", S_CD, 2, 1, 1, 1, 0, 0, 0);
    run(1, "play_enter", S_PLAY, 2, 1, 0, 0, 0, 0, 0);
    run(7, "tick_l1_pre", S_PLAY, 2, 1, 0, 0, 0, 0, 0);
    run(1, "tick_l1_first", S_PLAY, 2, 1, 0, 0, 1, 0, 0);
    run(1, "tick_l1_low", S_PLAY, 2, 1, 0, 0, 0, 0, 0);
    run(6, "tick_l1_pre2", S_PLAY, 2, 1, 0, 0, 0, 0, 0);
    run(1, "tick_l1_second", S_PLAY, 2, 1, 0, 0, 1, 0, 0);

    // 2: goal at level 1 -> one LEVELUP cycle -> COUNTDOWN at level 2, period 6
    frogT_i = 9'd90;
    run(1, "levelup", S_LUP, 2, 1, 0, 1, 0, 0, 0);
    frogT_i = 9'd300;
    run(1, "lvl2_cd", S_CD, 2, 2, 2, 1, 0, 0, 0);
    run(19, "lvl2_cd_end", S_CD, 2, 2, 1, 1, 0, 0, 0);
    run(1, "lvl2_play", S_PLAY, 2, 2, 0, 0, 0, 0, 0);
    run(5, "tick_l2_pre", S_PLAY, 2, 2, 0, 0, 0, 0, 0);
    run(1, "tick_l2_first", S_PLAY, 2, 2, 0, 0, 1, 0, 0);
    run(5, "tick_l2_pre2", S_PLAY, 2, 2, 0, 0, 0, 0, 0);
    run(1, "tick_l2_second", S_PLAY, 2, 2, 0, 0, 1, 0, 0);

    // 3: hit with 2 lives, collision held through HIT, back to PLAY
    collision_i = 1'b1;
    run(1, "hit_enter", S_HIT, 1, 2, 0, 1, 0, 0, 0);
    run(4, "hit_held", S_HIT, 1, 2, 0, 1, 0, 0, 0);
    run(1, "hit_exit", S_PLAY, 1, 2, 0, 0, 0, 0, 0);

    // 4: hit with last life -> OVER, sticky, restart
    run(1, "over_enter", S_OVER, 0, 2, 0, 1, 0, 0, 1);
    collision_i = 1'b0;
    run(100, "over_sticky", S_OVER, 0, 2, 0, 1, 0, 0, 1);
    start_i = 1'b1;
    run(1, "over_restart", S_CD, 2, 1, 2, 1, 0, 0, 0);
    start_i = 1'b0;

    // 5: collision+goal together -> HIT; goal alone at max level -> WIN
    run(19, "g5_cd_end", S_CD, 2, 1, 1, 1, 0, 0, 0);
    run(1, "g5_play1", S_PLAY, 2, 1, 0, 0, 0, 0, 0);
    frogT_i = 9'd90;
    run(1, "g5_levelup", S_LUP, 2, 1, 0, 1, 0, 0, 0);
    frogT_i = 9'd300;
    run(1, "g5_cd2", S_CD, 2, 2, 2, 1, 0, 0, 0);
    run(20, "g5_play2", S_PLAY, 2, 2, 0, 0, 0, 0, 0);
    frogT_i = 9'd80;
    collision_i = 1'b1;
    run(1, "coll_beats_goal", S_HIT, 1, 2, 0, 1, 0, 0, 0);
    collision_i = 1'b0;
    frogT_i = 9'd300;
    run(4, "g5_hit_held", S_HIT, 1, 2, 0, 1, 0, 0, 0);
    run(1, "g5_hit_exit", S_PLAY, 1, 2, 0, 0, 0, 0, 0);
    frogT_i = 9'd80;
    run(1, "win_enter", S_WIN, 1, 2, 0, 1, 0, 1, 0);
    frogT_i = 9'd300;
    run(10, "win_sticky", S_WIN, 1, 2, 0, 1, 0, 1, 0);

    // 6: reset mid-COUNTDOWN and mid-HIT
    start_i = 1'b1;
    run(1, "win_restart", S_CD, 2, 1, 2, 1, 0, 0, 0);
    start_i = 1'b0;
    run(5, "mid_cd", S_CD, 2, 1, 2, 1, 0, 0, 0);
    reset_in = 1'b1;
    run(1, "reset_mid_cd", S_IDLE, 2, 1, 2, 1, 0, 0, 0);
    reset_in = 1'b0;
    start_i = 1'b1;
    run(1, "after_rst_cd", S_CD, 2, 1, 2, 1, 0, 0, 0);
    start_i = 1'b0;
    run(9, "after_rst_cd2", S_CD, 2, 1, 2, 1, 0, 0, 0);
    run(1, "after_rst_cd1", S_CD, 2, 1, 1, 1, 0, 0, 0);
    run(10, "after_rst_play", S_PLAY, 2, 1, 0, 0, 0, 0, 0);
    collision_i = 1'b1;
    run(1, "hit2_enter", S_HIT, 1, 1, 0, 1, 0, 0, 0);
    collision_i = 1'b0;
    run(2, "mid_hit", S_HIT, 1, 1, 0, 1, 0, 0, 0);
    reset_in = 1'b1;
    run(1, "reset_mid_hit", S_IDLE, 2, 1, 2, 1, 0, 0, 0);
    reset_in = 1'b0;
    run(3, "idle_after_rst", S_IDLE, 2, 1, 2, 1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
